// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with frame debounce and key-code FIFO.
// Rows are driven active-low one at a time, columns are read back, whole-matrix
// frames are debounced and each new press queues its code (row*4 + col).
module keypad_scan #(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned DEBOUNCE_CNT = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] row_o,
  input  logic [3:0] col_i,
  output logic       key_valid_o,
  output logic [3:0] key_code_o,
  input  logic       key_pop_i,
  output logic       overflow_o,
  input  logic       ovf_clr_i,
  output logic       irq_o
);

  localparam int unsigned CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned MC_W   = $clog2(DEBOUNCE_CNT + 1);
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam bit          DC_ONE = (DEBOUNCE_CNT == 1);

  logic [3:0]        col_s1, col_s2;
  logic [CNT_W-1:0]  slot_cnt;
  logic [1:0]        row_idx;
  logic [15:0]       frame_map, prev_map, stable_map, old_stable;
  logic [MC_W-1:0]   match_cnt;
  logic [3:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FCNT_W-1:0] fifo_cnt;

  logic [3:0]        pressed;
  logic              slot_end, frame_end, map_diff, stable_load;
  logic [15:0]       full_map, new_keys;
  logic              push_req, pop_acc, push_acc, fifo_full, ovf_set;
  logic [3:0]        push_code, head_next;
  logic [PTR_W-1:0]  wr_ptr_next, rd_ptr_next;
  logic [FCNT_W-1:0] fifo_cnt_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Scan timing, completed frame map and debounce decision.
  always_comb begin
    pressed     = ~col_s2;
    slot_end    = (slot_cnt == CNT_W'(SCAN_DIV - 1));
    frame_end   = slot_end && (row_idx == 2'd3);
    full_map    = {pressed, frame_map[11:0]};
    map_diff    = (full_map != prev_map);
    stable_load = frame_end &&
                  (map_diff ? DC_ONE : (match_cnt == MC_W'(DEBOUNCE_CNT - 1)));
  end

  // New-press detection: lowest newly set index wins, others are discarded.
  always_comb begin
    new_keys  = stable_map & ~old_stable;
    push_req  = |new_keys;
    push_code = '0;
    for (int i = 15; i >= 0; i--) begin
      if (new_keys[i]) push_code = 4'(i);
    end
  end

  // FIFO control: a pop in the same cycle makes room for a push into a full FIFO.
  always_comb begin
    pop_acc       = key_pop_i && (fifo_cnt != '0);
    fifo_full     = (fifo_cnt == FCNT_W'(FIFO_DEPTH));
    push_acc      = push_req && (!fifo_full || pop_acc);
    ovf_set       = push_req && fifo_full && !pop_acc;
    rd_ptr_next   = pop_acc ? ptr_inc(rd_ptr) : rd_ptr;
    wr_ptr_next   = push_acc ? ptr_inc(wr_ptr) : wr_ptr;
    fifo_cnt_next = fifo_cnt;
    if (push_acc && !pop_acc) fifo_cnt_next = fifo_cnt + 1'b1;
    else if (!push_acc && pop_acc) fifo_cnt_next = fifo_cnt - 1'b1;
    head_next = (push_acc && (wr_ptr == rd_ptr_next)) ? push_code : fifo_mem[rd_ptr_next];
  end

  // Two-flop synchronizer for the asynchronous column inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_s1 <= 4'hF;
      col_s2 <= 4'hF;
    end else begin
      col_s1 <= col_i;
      col_s2 <= col_s1;
    end
  end

  // Row slot counter, row rotation and per-row column capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt  <= '0;
      row_idx   <= '0;
      row_o     <= 4'b1110;
      frame_map <= '0;
    end else if (slot_end) begin
      slot_cnt  <= '0;
      row_idx   <= row_idx + 2'd1;
      row_o     <= {row_o[2:0], row_o[3]};
      frame_map[{row_idx, 2'b00} +: 4] <= pressed;
    end else begin
      slot_cnt  <= slot_cnt + 1'b1;
    end
  end

  // Frame debounce: stable map follows after DEBOUNCE_CNT identical frames.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_map   <= '0;
      match_cnt  <= '0;
      stable_map <= '0;
      old_stable <= '0;
    end else begin
      old_stable <= stable_map;
      if (frame_end) begin
        if (map_diff) begin
          prev_map  <= full_map;
          match_cnt <= MC_W'(1);
        end else if (match_cnt < MC_W'(DEBOUNCE_CNT)) begin
          match_cnt <= match_cnt + 1'b1;
        end
      end
      if (stable_load) stable_map <= full_map;
    end
  end

  // Key-code FIFO storage, pointers and registered head/status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_mem[i] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      key_valid_o <= 1'b0;
      irq_o       <= 1'b0;
      key_code_o  <= '0;
    end else begin
      if (push_acc) fifo_mem[wr_ptr] <= push_code;
      wr_ptr      <= wr_ptr_next;
      rd_ptr      <= rd_ptr_next;
      fifo_cnt    <= fifo_cnt_next;
      key_valid_o <= (fifo_cnt_next != '0);
      irq_o       <= (fifo_cnt_next != '0);
      key_code_o  <= head_next;
    end
  end

  // Sticky overflow flag; a new overflow beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n)          overflow_o <= 1'b0;
    else if (ovf_set)    overflow_o <= 1'b1;
    else if (ovf_clr_i)  overflow_o <= 1'b0;
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: frame-level reference model of the keypad scanner with
// directed scenarios followed by randomized key/pop/clear traffic.
module tb_keypad_scan;

  localparam int unsigned SCAN_DIV     = 4;
  localparam int unsigned DEBOUNCE_CNT = 2;
  localparam int unsigned FIFO_DEPTH   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_o;
  logic [3:0] col_i;
  logic       key_valid_o;
  logic [3:0] key_code_o;
  logic       key_pop_i = 1'b0;
  logic       overflow_o;
  logic       ovf_clr_i = 1'b0;
  logic       irq_o;
  logic [15:0] keys = '0;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state (one step per 16-cycle frame).
  int          q[$];
  logic [15:0] m_prev, m_stable;
  int          m_cnt;
  bit          m_ovf;
  int          m_pend;

  keypad_scan #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row_o(row_o), .col_i(col_i),
    .key_valid_o(key_valid_o), .key_code_o(key_code_o), .key_pop_i(key_pop_i),
    .overflow_o(overflow_o), .ovf_clr_i(ovf_clr_i), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key shorts its row to its column.
  always_comb begin
    col_i = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row_o[r]) col_i = col_i & ~keys[r*4 +: 4];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    m_prev = '0; m_stable = '0; m_cnt = 0; m_ovf = 1'b0; m_pend = -1;
  endtask

  task automatic model_push();
    if (m_pend >= 0) begin
      if (q.size() < int'(FIFO_DEPTH)) q.push_back(m_pend);
      else m_ovf = 1'b1;
    end
    m_pend = -1;
  endtask

  task automatic model_pop();
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic model_frame(input logic [15:0] k);
    bit upd;
    logic [15:0] nw;
    upd = 1'b0;
    if (k != m_prev) begin
      m_prev = k; m_cnt = 1; upd = (DEBOUNCE_CNT == 1);
    end else if (m_cnt < int'(DEBOUNCE_CNT)) begin
      m_cnt++; upd = (m_cnt == int'(DEBOUNCE_CNT));
    end
    if (upd) begin
      nw = k & ~m_stable;
      m_stable = k;
      for (int i = 0; i < 16; i++) begin
        if (nw[i]) begin m_pend = i; break; end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_valid"}, 32'(key_valid_o), 32'(q.size() != 0));
    check_eq({tag, "_irq"}, 32'(irq_o), 32'(q.size() != 0));
    check_eq({tag, "_ovf"}, 32'(overflow_o), 32'(m_ovf));
    if (q.size() != 0) check_eq({tag, "_code"}, 32'(key_code_o), 32'(q[0]));
  endtask

  // One frame with keys held; pop_mode 1 pops mid-frame, 2 pops on the push edge.
  task automatic frame(input logic [15:0] k, input int pop_mode, input bit clr);
    keys = k;
    if (pop_mode == 2) begin
      key_pop_i = 1'b1; cyc(); key_pop_i = 1'b0;
      model_pop(); model_push();
    end else begin
      cyc(); model_push();
    end
    cyc();
    check_outputs("frm");
    check_eq("frm_row", 32'(row_o), 32'(4'b1110));
    if (pop_mode == 1) begin
      key_pop_i = 1'b1; cyc(); key_pop_i = 1'b0; model_pop();
    end else cyc();
    if (clr) begin
      ovf_clr_i = 1'b1; cyc(); ovf_clr_i = 1'b0; m_ovf = 1'b0;
    end else cyc();
    repeat (12) cyc();
    model_frame(k);
  endtask

  task automatic frames(input logic [15:0] k, input int n);
    for (int i = 0; i < n; i++) frame(k, 0, 1'b0);
  endtask

  initial begin
    logic [15:0] k, rk;
    int hold;
    #1;
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    model_reset();

    // Reset values and idle row rotation over four frames.
    check_eq("rst_code", 32'(key_code_o), 32'd0);
    for (int i = 0; i < 64; i++) begin
      check_eq("idle_row", 32'(row_o), 32'(~(4'b0001 << ((i / 4) % 4)) & 4'hF));
      check_eq("idle_valid", 32'(key_valid_o), 32'd0);
      check_eq("idle_ovf", 32'(overflow_o), 32'd0);
      check_eq("idle_irq", 32'(irq_o), 32'd0);
      cyc();
    end
    for (int i = 0; i < 4; i++) model_frame('0);

    // One-frame glitch on key 9 is filtered out.
    frame(16'h0200, 0, 1'b0);
    frames('0, 3);
    check_eq("pulse_valid", 32'(key_valid_o), 32'd0);

    // Held key 9 gives exactly one event; pop empties; re-press gives another.
    frames(16'h0200, 6);
    check_eq("hold_valid", 32'(key_valid_o), 32'd1);
    check_eq("hold_code", 32'(key_code_o), 32'd9);
    check_eq("hold_irq", 32'(irq_o), 32'd1);
    frame(16'h0200, 1, 1'b0);
    check_eq("pop_valid", 32'(key_valid_o), 32'd0);
    frames('0, 3);
    frames(16'h0200, 3);
    check_eq("repress_code", 32'(key_code_o), 32'd9);
    check_eq("repress_valid", 32'(key_valid_o), 32'd1);
    frame(16'h0200, 1, 1'b0);
    frames('0, 3);

    // Keys 3 and 12 together: only the lowest code is queued.
    k = 16'h1008;
    frames(k, 3);
    check_eq("combo_code", 32'(key_code_o), 32'd3);
    frame(k, 1, 1'b0);
    check_eq("combo_single", 32'(key_valid_o), 32'd0);
    frames('0, 3);

    // Five presses without popping: fifth is dropped and flags overflow.
    for (int c = 0; c < 5; c++) begin
      frames(16'(1 << c), 2);
      frames('0, 2);
    end
    check_eq("ovf_set", 32'(overflow_o), 32'd1);
    for (int j = 0; j < 4; j++) begin
      check_eq("ovf_order", 32'(key_code_o), 32'(j));
      frame('0, 1, 1'b0);
    end
    check_eq("ovf_drained", 32'(key_valid_o), 32'd0);
    frame('0, 0, 1'b1);
    check_eq("ovf_clr", 32'(overflow_o), 32'd0);

    // Full FIFO with a pop on the push edge: push accepted, no overflow.
    for (int c = 5; c < 9; c++) begin
      frames(16'(1 << c), 2);
      frames('0, 2);
    end
    frames(16'h0200, 2);
    frame('0, 2, 1'b0);
    check_eq("simul_ovf", 32'(overflow_o), 32'd0);
    check_eq("simul_head", 32'(key_code_o), 32'd6);
    for (int j = 6; j < 10; j++) begin
      check_eq("simul_order", 32'(key_code_o), 32'(j));
      frame('0, 1, 1'b0);
    end
    check_eq("simul_drained", 32'(key_valid_o), 32'd0);

    // Mid-slot reset with a key held and two entries queued.
    frames(16'h0020, 2);
    k = 16'h0060;
    frames(k, 2);
    keys = k;
    cyc(); model_push();
    cyc();
    check_outputs("pre_rst");
    check_eq("pre_rst_cnt", 32'(q.size()), 32'd2);
    repeat (4) cyc();
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    model_reset();
    check_eq("mrst_row", 32'(row_o), 32'(4'b1110));
    check_eq("mrst_valid", 32'(key_valid_o), 32'd0);
    check_eq("mrst_ovf", 32'(overflow_o), 32'd0);
    check_eq("mrst_irq", 32'(irq_o), 32'd0);
    frames(k, 2);
    check_eq("mrst_early", 32'(key_valid_o), 32'd0);
    frame(k, 0, 1'b0);
    check_eq("mrst_redetect", 32'(key_valid_o), 32'd1);
    check_eq("mrst_code", 32'(key_code_o), 32'd5);

    // Randomized key patterns, pops and clears against the model.
    rk = k;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: rk = '0;
        1: rk = 16'(1 << $urandom_range(0, 15));
        2: rk = 16'(1 << $urandom_range(0, 15)) | 16'(1 << $urandom_range(0, 15));
        default: ;
      endcase
      hold = $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) begin
        frame(rk, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
              ($urandom_range(0, 7) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
